// File: rtl/sync_sram_dp.sv
`default_nettype none
// ============================================================================
// Module : sync_sram_dp
// Simple-dual-port SRAM with byte-enabled writes, 1/2-cycle registered reads
// and a clear engine that zeroes the array after reset or on request.
// Rev    : 1.0
// ============================================================================
module sync_sram_dp #(
   parameter int ADDR_WIDTH   = 12,
   parameter int DATA_WIDTH   = 16,
   parameter int DATA_DEPTH   = 4096,
   parameter int READ_LATENCY = 1,
   parameter bit BYPASS       = 1'b1
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    clr,
   output logic                    busy,
   input  logic                    we,
   input  logic [ADDR_WIDTH-1:0]   waddr,
   input  logic [DATA_WIDTH-1:0]   wdata,
   input  logic [DATA_WIDTH/8-1:0] wbe,
   input  logic                    re,
   input  logic [ADDR_WIDTH-1:0]   raddr,
   output logic [DATA_WIDTH-1:0]   rdata,
   output logic                    rvalid
);

   localparam int               NBYTES = DATA_WIDTH / 8;
   localparam int               IDX_W  = (DATA_DEPTH > 1) ? $clog2(DATA_DEPTH) : 1;
   localparam logic [IDX_W-1:0] C_LAST = IDX_W'(DATA_DEPTH - 1);

   typedef enum logic [0:0] {
      CLEAR = 1'b0,
      READY = 1'b1
   } state_t;

   state_t                state_q, state_d;
   logic [IDX_W-1:0]      cnt_q, cnt_d;
   logic [DATA_WIDTH-1:0] mem_q [DATA_DEPTH];
   logic [DATA_WIDTH-1:0] rdata_q;
   logic                  rvalid_q;

   logic                  w_ready, w_wr_in, w_rd_in, w_wr_acc, w_rd_acc;
   logic [IDX_W-1:0]      w_widx, w_ridx;
   logic [DATA_WIDTH-1:0] w_rword, w_merged, w_rcapt;

   assign w_ready  = (state_q == READY);
   assign busy     = ~w_ready;
   assign w_wr_in  = (32'(waddr) < DATA_DEPTH);
   assign w_rd_in  = (32'(raddr) < DATA_DEPTH);
   assign w_wr_acc = w_ready & we & ~clr & w_wr_in;
   assign w_rd_acc = w_ready & re & ~clr;
   assign w_widx   = waddr[IDX_W-1:0];
   assign w_ridx   = raddr[IDX_W-1:0];
   assign rdata    = rdata_q;
   assign rvalid   = rvalid_q;

   // Read capture: optional byte-merged forward of a same-address write.
   always_comb begin
      w_rword  = mem_q[w_ridx];
      w_merged = w_rword;
      for (int i = 0; i < NBYTES; i++) begin
         if (wbe[i]) w_merged[8*i +: 8] = wdata[8*i +: 8];
      end
      w_rcapt = w_rword;
      if (BYPASS && w_wr_acc && (waddr == raddr)) w_rcapt = w_merged;
      if (!w_rd_in) w_rcapt = '0;
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         CLEAR: begin
            cnt_d = cnt_q + IDX_W'(1);
            if (cnt_q == C_LAST) begin
               state_d = READY;
               cnt_d   = '0;
            end
         end
         READY: begin
            if (clr) state_d = CLEAR;
         end
         default: state_d = CLEAR;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= CLEAR;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   always_ff @(posedge clk) begin
      if (!w_ready) begin
         mem_q[cnt_q] <= '0;
      end else if (w_wr_acc) begin
         for (int i = 0; i < NBYTES; i++) begin
            if (wbe[i]) mem_q[w_widx][8*i +: 8] <= wdata[8*i +: 8];
         end
      end
   end

   generate
      if (READ_LATENCY == 2) begin : g_lat2
         logic [DATA_WIDTH-1:0] s0_data_q;
         logic                  s0_vld_q;

         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               s0_vld_q  <= 1'b0;
               s0_data_q <= '0;
               rvalid_q  <= 1'b0;
               rdata_q   <= '0;
            end else begin
               s0_vld_q <= w_rd_acc;
               if (w_rd_acc) s0_data_q <= w_rcapt;
               rvalid_q <= s0_vld_q;
               if (s0_vld_q) rdata_q <= s0_data_q;
            end
         end
      end else begin : g_lat1
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               rvalid_q <= 1'b0;
               rdata_q  <= '0;
            end else begin
               rvalid_q <= w_rd_acc;
               if (w_rd_acc) rdata_q <= w_rcapt;
            end
         end
      end
   endgenerate

endmodule
`default_nettype wire

// File: tb/tb_sync_sram_dp.sv
`default_nettype none
// ============================================================================
// Module : tb_sync_sram_dp
// Two DUTs (BYPASS=1/latency 2, BYPASS=0/latency 1) share one stimulus stream;
// each has its own expected-response queue drained by a monitor.
// Rev    : 1.0
// ============================================================================
module tb_sync_sram_dp;

   localparam int AW    = 5;
   localparam int DW    = 16;
   localparam int DEPTH = 16;
   localparam int LAT_A = 2;
   localparam int LAT_B = 1;

   logic          clk = 1'b0, rst_n = 1'b0, clr = 1'b0, we = 1'b0, re = 1'b0;
   logic [AW-1:0] waddr = '0, raddr = '0;
   logic [DW-1:0] wdata = '0;
   logic [1:0]    wbe = '0;
   logic          busy_a, busy_b, rvalid_a, rvalid_b;
   logic [DW-1:0] rdata_a, rdata_b;

   int total = 0, bad = 0, cyc = 0;

   typedef struct {
      logic [15:0] data;
      int          cycle;
   } exp_t;

   exp_t        qa[$], qb[$];
   exp_t        ea, eb;
   logic [15:0] last_a = '0, last_b = '0;

   sync_sram_dp #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DATA_DEPTH(DEPTH),
                  .READ_LATENCY(LAT_A), .BYPASS(1'b1)) u_a (
      .clk(clk), .rst_n(rst_n), .clr(clr), .busy(busy_a),
      .we(we), .waddr(waddr), .wdata(wdata), .wbe(wbe),
      .re(re), .raddr(raddr), .rdata(rdata_a), .rvalid(rvalid_a));

   sync_sram_dp #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DATA_DEPTH(DEPTH),
                  .READ_LATENCY(LAT_B), .BYPASS(1'b0)) u_b (
      .clk(clk), .rst_n(rst_n), .clr(clr), .busy(busy_b),
      .we(we), .waddr(waddr), .wdata(wdata), .wbe(wbe),
      .re(re), .raddr(raddr), .rdata(rdata_b), .rvalid(rvalid_b));

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s: got %0h, required %0h", name, act, req);
      end
   endtask

   always @(negedge clk) begin
      if (rst_n) begin
         if (rvalid_a) begin
            if (qa.size() == 0) begin
               total++; bad++;
               $display("FAIL A unexpected rvalid: rdata %0h, no read outstanding", rdata_a);
            end else begin
               ea = qa.pop_front();
               check("A rdata", 32'(rdata_a), 32'(ea.data));
               check("A rvalid cycle", 32'(cyc), 32'(ea.cycle));
               last_a = ea.data;
            end
         end else begin
            check("A rdata hold", 32'(rdata_a), 32'(last_a));
         end
         if (rvalid_b) begin
            if (qb.size() == 0) begin
               total++; bad++;
               $display("FAIL B unexpected rvalid: rdata %0h, no read outstanding", rdata_b);
            end else begin
               eb = qb.pop_front();
               check("B rdata", 32'(rdata_b), 32'(eb.data));
               check("B rvalid cycle", 32'(cyc), 32'(eb.cycle));
               last_b = eb.data;
            end
         end else begin
            check("B rdata hold", 32'(rdata_b), 32'(last_b));
         end
      end
   end

   // One cycle of stimulus; inputs are driven 1 time unit after a rising edge.
   task automatic op(input logic w, input logic [AW-1:0] wa, input logic [15:0] wd,
                     input logic [1:0] be, input logic r, input logic [AW-1:0] ra,
                     input logic [15:0] exp_a, input logic [15:0] exp_b);
      we = w; waddr = wa; wdata = wd; wbe = be; re = r; raddr = ra;
      if (r) begin
         qa.push_back('{exp_a, cyc + LAT_A});
         qb.push_back('{exp_b, cyc + LAT_B});
      end
      @(posedge clk); #1;
      we = 1'b0; re = 1'b0;
   endtask

   task automatic rd(input logic [AW-1:0] a, input logic [15:0] e);
      op(1'b0, '0, '0, 2'b00, 1'b1, a, e, e);
   endtask

   task automatic wr(input logic [AW-1:0] a, input logic [15:0] d, input logic [1:0] be);
      op(1'b1, a, d, be, 1'b0, '0, '0, '0);
   endtask

   task automatic measure_clear(input string name);
      int na = 0, nb = 0;
      for (int n = 1; n <= 100 && (na == 0 || nb == 0); n++) begin
         @(posedge clk); #1;
         if (!busy_a && na == 0) na = n;
         if (!busy_b && nb == 0) nb = n;
      end
      check({name, " A"}, 32'(na), 32'(DEPTH));
      check({name, " B"}, 32'(nb), 32'(DEPTH));
   endtask

   task automatic drain();
      int n = 0;
      while ((qa.size() != 0 || qb.size() != 0) && n < 50) begin
         @(posedge clk); #1;
         n++;
      end
      total++;
      if (qa.size() != 0 || qb.size() != 0) begin
         bad++;
         $display("FAIL drain: outstanding A=%0d B=%0d, required 0", qa.size(), qb.size());
         qa.delete(); qb.delete();
      end
   endtask

   task automatic chk_reset(input string name);
      check({name, " busy A"}, 32'(busy_a), 32'd1);
      check({name, " busy B"}, 32'(busy_b), 32'd1);
      check({name, " rvalid A"}, 32'(rvalid_a), 32'd0);
      check({name, " rvalid B"}, 32'(rvalid_b), 32'd0);
      check({name, " rdata A"}, 32'(rdata_a), 32'd0);
      check({name, " rdata B"}, 32'(rdata_b), 32'd0);
   endtask

   task automatic flush();
      qa.delete(); qb.delete();
      last_a = '0; last_b = '0;
   endtask

   initial begin
      repeat (3) @(posedge clk); #1;
      chk_reset("por");
      rst_n = 1'b1;
      measure_clear("por clear length");
      for (int i = 0; i < DEPTH; i++) rd(AW'(i), 16'h0000);
      drain();

      wr(5'd5, 16'hBEEF, 2'b11);
      wr(5'd5, 16'h1234, 2'b10);
      rd(5'd5, 16'h12EF);
      wr(5'd3, 16'h1111, 2'b11);
      op(1'b1, 5'd3, 16'hA5A5, 2'b11, 1'b1, 5'd3, 16'hA5A5, 16'h1111);
      op(1'b1, 5'd3, 16'h00CC, 2'b01, 1'b1, 5'd3, 16'hA5CC, 16'hA5A5);
      rd(5'd3, 16'hA5CC);
      drain();

      for (int i = 0; i < 8; i++) wr(AW'(i), 16'hC000 | (16'(i) * 16'h0101), 2'b11);
      for (int i = 0; i < 8; i++) rd(AW'(i), 16'hC000 | (16'(i) * 16'h0101));
      rd(5'd20, 16'h0000);
      wr(5'd20, 16'hFFFF, 2'b11);
      rd(5'd20, 16'h0000);
      rd(5'd4, 16'hC404);
      drain();

      // Read just before clr must complete; traffic alongside/during clear is ignored.
      rd(5'd5, 16'hC505);
      we = 1'b1; waddr = 5'd0; wdata = 16'hFFFF; wbe = 2'b11; re = 1'b1; raddr = 5'd5;
      clr = 1'b1;
      @(posedge clk); #1;
      clr = 1'b0;
      check("clr busy A", 32'(busy_a), 32'd1);
      check("clr busy B", 32'(busy_b), 32'd1);
      measure_clear("clr clear length");
      we = 1'b0; re = 1'b0;
      for (int i = 0; i < DEPTH; i++) rd(AW'(i), 16'h0000);
      drain();

      wr(5'd9, 16'h5A5A, 2'b11);
      rd(5'd9, 16'h5A5A);
      drain();
      rd(5'd9, 16'h5A5A);
      rst_n = 1'b0;
      flush();
      #1;
      chk_reset("mid-read reset");
      repeat (2) @(posedge clk); #1;
      chk_reset("held reset");
      rst_n = 1'b1;
      measure_clear("post-reset clear length");

      wr(5'd2, 16'h7777, 2'b11);
      rd(5'd2, 16'h7777);
      drain();
      clr = 1'b1;
      @(posedge clk); #1;
      clr = 1'b0;
      repeat (5) @(posedge clk); #1;
      rst_n = 1'b0;
      flush();
      #1;
      chk_reset("mid-clear reset");
      @(posedge clk); #1;
      rst_n = 1'b1;
      measure_clear("restarted clear length");
      rd(5'd2, 16'h0000);
      rd(5'd9, 16'h0000);
      rd(5'd5, 16'h0000);
      drain();

      repeat (3) @(posedge clk); #1;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish within time limit");
      $fatal(1, "watchdog expired");
   end

endmodule
`default_nettype wire

// File: doc/sync_sram_dp.md
# sync_sram_dp

Parametrised synchronous simple-dual-port SRAM: one write port with byte enables, one read port, and a registered read pipeline of configurable latency. It adds a hardware clear engine that zeroes the whole array after reset or on request. It is the next-generation instruction/data memory for the pipelined CPU and replaces the level-sensitive single-port array with a clocked, deterministic one.

## Interface

- ADDR_WIDTH, 12, address width of both ports
- DATA_WIDTH, 16, word width; must be a multiple of 8
- DATA_DEPTH, 4096, number of words; must be ≤ 2^ADDR_WIDTH
- READ_LATENCY, 1, edges from read request to rvalid; legal values 1 or 2
- BYPASS, 1, 1 = read-during-write to the same address returns new data; 0 = returns old data

Ports:

- clk  in  1  single clock; all state changes on the rising edge
- rst_n  in  1  asynchronous, active-low reset
- clr  in  1  request to re-zero the array; sampled only while busy=0
- busy  out  1  clear engine active; all requests ignored
- we  in  1  write request
- waddr  in  ADDR_WIDTH  write address
- wdata  in  DATA_WIDTH  write data
- wbe  in  DATA_WIDTH/8  byte enables; bit i covers wdata[8i+7:8i]
- re  in  1  read request
- raddr  in  ADDR_WIDTH  read address
- rdata  out  DATA_WIDTH  read data; valid when rvalid=1
- rvalid  out  1  one-cycle pulse per accepted read

## Operation

- FSM states: CLEAR, READY. Reset forces CLEAR with the clear counter at 0.
- CLEAR:
  - each edge writes 0 to mem[cnt] and increments cnt
  - at cnt = DATA_DEPTH-1 the state becomes READY and cnt returns to 0
  - busy=1 throughout; we and re are ignored; no new rvalid is produced
- READY:
  - busy=0
  - clr=1 moves the FSM to CLEAR on the next edge; we/re in that same cycle are ignored (clr has priority)
- Write (READY, we=1, clr=0): only the bytes with wbe[i]=1 are updated. wbe=0 is a no-op. waddr ≥ DATA_DEPTH is dropped silently.
- Read (READY, re=1, clr=0):
  - mem[raddr] is captured and enters the read pipeline
  - raddr ≥ DATA_DEPTH returns 0 with rvalid=1
- Read-during-write, same address, same edge:
  - BYPASS=1: rdata is the byte-merged new word (new bytes where wbe=1, old bytes elsewhere)
  - BYPASS=0: rdata is the pre-write word
- Different addresses: the read and the write are fully independent.
- Reads accepted before clr still complete normally, with their captured data, while busy=1.
- rdata holds its last value when rvalid=0.

## Timing

- Reset values, asserted asynchronously:
  - rdata = 0, rvalid = 0, busy = 1
  - state = CLEAR, cnt = 0, read pipeline valid bits = 0
  - array contents are not reset directly; the clear engine zeroes them
- Clear duration is exactly DATA_DEPTH edges:
  - busy falls at the DATA_DEPTH-th rising edge after rst_n deasserts, or after the edge that sampled clr
  - a request in the first cycle with busy=0 is accepted
- Read latency:
  - re sampled at edge N gives rvalid=1 and valid rdata after edge N+READ_LATENCY-1
  - READ_LATENCY=1: visible in the cycle right after edge N
  - READ_LATENCY=2: one cycle later
- Full throughput: one read and one write accepted every cycle; rvalid can stay high back-to-back.
- Write visibility: data written at edge N is returned by a read sampled at edge N+1 or later, independent of BYPASS.
- Reset mid-operation, including mid-clear: immediate return to reset values, in-flight reads discarded, clear restarts from cnt=0.

## Test plan

- Reset release, DATA_DEPTH=16: busy=1 for exactly 16 edges. Read of every address then returns 0, and rvalid follows each re by READ_LATENCY.
- Write 0xBEEF to addr 5 with wbe=2'b11, then write 0x12xx with wbe=2'b10 -> read addr 5 returns 0x12EF.
- Same-edge write 0xA5A5 (wbe=2'b11) and read of addr 3 holding 0x1111 -> rdata=0xA5A5 with BYPASS=1, 0x1111 with BYPASS=0. The next read returns 0xA5A5 in both cases.
- Back-to-back reads of addrs 0..7 with re held high (READ_LATENCY=2) -> 8 consecutive rvalid pulses starting 2 cycles later, data in order. An out-of-range addr 20 (DATA_DEPTH=16) returns 0 with rvalid=1, and a write to addr 20 changes nothing.
- clr pulsed with we=1 in the same cycle -> the write is ignored, busy=1 for DATA_DEPTH edges, and all addresses read 0 afterwards. A read issued one cycle before clr still returns its old data.
- rst_n dropped mid-clear and mid-read -> rvalid=0, rdata=0, busy=1 immediately. After release the full DATA_DEPTH-cycle clear runs again.
